ps2_cmd_decoder: RTL
====================

Name: ps2_cmd_decoder

Overview:
- Sits between the PS2 byte receiver (data_out/ready) and the game control logic in top.
- Turns the raw scan-code byte stream into clean single-cycle command pulses: fast, slow, flip direction, any key.
- Parses set-2 E0/F0 prefixes and suppresses typematic auto-repeat, so the game FSM never sees duplicate or break-code events.
- Replaces ad-hoc last_key/wasReady tracking in the game logic.

Parameters:
KEY_FAST, 8'h3B, make code that produces cmd_fast
KEY_SLOW, 8'h42, make code that produces cmd_slow
KEY_FLIP, 8'h4B, make code that produces cmd_flip
TIMEOUT_CYC, 2_000_000, clk cycles a prefix state may wait for its next byte (20 ms at 100 MHz)

Ports:
clk  in  1  system clock, 100 MHz
rstn  in  1  reset, asynchronous assert, active-low
ps2_ready  in  1  byte-valid level from PS2 receiver; a new byte is presented on each low->high transition
ps2_byte  in  8  scan-code byte, stable while ps2_ready high
cmd_fast  out  1  one-cycle pulse, KEY_FAST pressed
cmd_slow  out  1  one-cycle pulse, KEY_SLOW pressed
cmd_flip  out  1  one-cycle pulse, KEY_FLIP pressed
any_key  out  1  one-cycle pulse on any new non-repeat make, extended or not
key_code  out  8  code of the last accepted make
key_ext  out  1  last accepted make was E0-prefixed
held_mask  out  3  {flip,slow,fast} currently held (make seen, break not yet seen)

Behaviour:
- Reset (rstn low, asynchronous): all outputs 0. ready_d=0, state IDLE, last_make=0, timeout counter 0.
- Byte event: ps2_ready=1 and ready_d=0 at a clk edge; ready_d <= ps2_ready every cycle. A level held high for many cycles yields exactly one event.
- Latency: the event is sampled at edge k; the resulting pulse is high from edge k+1 to edge k+2 only. key_code, key_ext and held_mask update at edge k+1.
- Byte 8'hAA or 8'hFA in IDLE: ignored, no output change.
- States IDLE, GOT_E0, GOT_F0, GOT_E0F0:
  - IDLE: E0->GOT_E0; F0->GOT_F0; other byte = plain make.
  - GOT_E0: F0->GOT_E0F0; E0 stays; other byte = extended make, ->IDLE.
  - GOT_F0: F0 stays; E0->GOT_E0 (protocol restart); other byte = plain break, ->IDLE.
  - GOT_E0F0: E0->GOT_E0; F0 stays; other byte = extended break, ->IDLE.
- Make handling, with code c and ext e:
  - If {e,c} == last_make: repeat, no pulses, nothing updated.
  - Otherwise: any_key=1, key_code=c, key_ext=e, last_make={e,c}.
  - If e=0 and c matches a KEY_* parameter and that key's held bit is 0: that key's cmd pulse fires and its held bit is set.
  - If the held bit is already 1, the cmd pulse is suppressed (any_key still fires).
  - Extended makes never fire cmd_* pulses.
- Break handling, with code c and ext e: clear the matching held bit (plain only). If {e,c} == last_make, clear last_make to 0. No pulses.
- Timeout: in any non-IDLE state the counter increments each cycle; it clears on every byte event and in IDLE. On reaching TIMEOUT_CYC-1, go to IDLE with no output. A byte event in the same cycle has priority over the timeout.
- At most one cmd_* pulse and one any_key per byte event; cmd pulses coincide with any_key.
- Reset mid-sequence: a pending prefix is discarded; the first byte after reset is parsed from IDLE.

Test Plan:
- Reset then 3B event -> cmd_fast=1 and any_key=1 for exactly one cycle, one cycle after the event; key_code=3B, key_ext=0, held_mask=3'b001.
- Stream 3B,3B,3B (typematic) -> a single cmd_fast/any_key pulse. Then F0,3B,3B -> held_mask=0, then a second cmd_fast pulse.
- Stream E0,4B -> any_key pulse, key_code=4B, key_ext=1, no cmd_flip; held_mask unchanged. Then E0,F0,4B -> no pulse, state IDLE.
- ps2_ready held high 50 cycles with byte 42 -> exactly one cmd_slow pulse.
- E0 then idle for TIMEOUT_CYC cycles, then 4B -> cmd_flip pulses (parsed as plain). Repeat with 4B arriving at cycle TIMEOUT_CYC-1 -> extended, no cmd_flip.
- F0 sent, rstn pulsed low mid-cycle, then 42 -> outputs clear asynchronously; the 42 produces cmd_slow (prefix discarded).

Source files
------------

// File: rtl/ps2_cmd_decoder.sv
// Turns the PS/2 set-2 scan-code byte stream into single-cycle game command pulses.
// Parses E0/F0 prefixes, drops typematic repeats and break codes, and times out stale prefixes.
module ps2_cmd_decoder #(
  parameter logic [7:0] KEY_FAST    = 8'h3B,
  parameter logic [7:0] KEY_SLOW    = 8'h42,
  parameter logic [7:0] KEY_FLIP    = 8'h4B,
  parameter int         TIMEOUT_CYC = 2_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_ready,
  input  logic [7:0] ps2_byte,
  output logic       cmd_fast,
  output logic       cmd_slow,
  output logic       cmd_flip,
  output logic       any_key,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic [2:0] held_mask
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

  state_t        state, state_nx;
  logic          ready_d, evt_q;
  logic [7:0]    byte_q;
  logic [CW-1:0] cnt, cnt_nx;
  logic [8:0]    last_make, last_make_nx;
  logic [2:0]    held_nx, key_hit, fire;
  logic [7:0]    code_nx;
  logic          ext_nx, fast_nx, slow_nx, flip_nx, any_nx;
  logic          is_make, is_break, ext;

  // Edge-detected byte is staged one cycle so results appear at k+1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_d   <= 1'b0;
      evt_q     <= 1'b0;
      byte_q    <= 8'h00;
      state     <= IDLE;
      cnt       <= '0;
      last_make <= 9'h000;
      cmd_fast  <= 1'b0;
      cmd_slow  <= 1'b0;
      cmd_flip  <= 1'b0;
      any_key   <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      held_mask <= 3'b000;
    end else begin
      ready_d   <= ps2_ready;
      evt_q     <= ps2_ready & ~ready_d;
      byte_q    <= ps2_byte;
      state     <= state_nx;
      cnt       <= cnt_nx;
      last_make <= last_make_nx;
      cmd_fast  <= fast_nx;
      cmd_slow  <= slow_nx;
      cmd_flip  <= flip_nx;
      any_key   <= any_nx;
      key_code  <= code_nx;
      key_ext   <= ext_nx;
      held_mask <= held_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    last_make_nx = last_make;
    held_nx      = held_mask;
    code_nx      = key_code;
    ext_nx       = key_ext;
    fast_nx      = 1'b0;
    slow_nx      = 1'b0;
    flip_nx      = 1'b0;
    any_nx       = 1'b0;
    is_make      = 1'b0;
    is_break     = 1'b0;
    ext          = 1'b0;
    fire         = 3'b000;
    key_hit      = {byte_q == KEY_FLIP, byte_q == KEY_SLOW, byte_q == KEY_FAST};

    if (evt_q) begin
      cnt_nx = '0;
      case (state)
        IDLE: begin
          if (byte_q == 8'hE0)      state_nx = GOT_E0;
          else if (byte_q == 8'hF0) state_nx = GOT_F0;
          else if (byte_q != 8'hAA && byte_q != 8'hFA) is_make = 1'b1;
        end
        GOT_E0: begin
          if (byte_q == 8'hF0) state_nx = GOT_E0F0;
          else if (byte_q != 8'hE0) begin
            is_make  = 1'b1;
            ext      = 1'b1;
            state_nx = IDLE;
          end
        end
        GOT_F0: begin
          if (byte_q == 8'hE0) state_nx = GOT_E0;
          else if (byte_q != 8'hF0) begin
            is_break = 1'b1;
            state_nx = IDLE;
          end
        end
        GOT_E0F0: begin
          if (byte_q == 8'hE0) state_nx = GOT_E0;
          else if (byte_q != 8'hF0) begin
            is_break = 1'b1;
            ext      = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end else if (state != IDLE) begin
      // A byte processed in the same cycle wins over the timeout (branch above).
      if (cnt == TO_LAST) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + CW'(1);
      end
    end else begin
      cnt_nx = '0;
    end

    if (is_make && ({ext, byte_q} != last_make)) begin
      any_nx       = 1'b1;
      code_nx      = byte_q;
      ext_nx       = ext;
      last_make_nx = {ext, byte_q};
      if (!ext) begin
        fire    = key_hit & ~held_mask;
        held_nx = held_mask | key_hit;
        fast_nx = fire[0];
        slow_nx = fire[1];
        flip_nx = fire[2];
      end
    end

    if (is_break) begin
      if (!ext) held_nx = held_mask & ~key_hit;
      if ({ext, byte_q} == last_make) last_make_nx = 9'h000;
    end
  end

endmodule
